// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM type, default widths and format helpers for the floating-point add unit
package fp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} fp_add_state_t;
  localparam int FP_EXP_WIDTH = 5;
  localparam int FP_MAN_WIDTH = 10;
  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction
  function automatic logic [63:0] fp_qnan(input int exp_width, input int man_width);
    return (((64'd1 << exp_width) - 64'd1) << man_width) | (64'd1 << (man_width - 1));
  endfunction
  function automatic logic [63:0] fp_inf(input int exp_width, input int man_width, input logic sign);
    return ({63'd0, sign} << (exp_width + man_width)) | (((64'd1 << exp_width) - 64'd1) << man_width);
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter; an all-zero input counts as WIDTH
module fp_lzc #(
  parameter int WIDTH = 14,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (value[i]) count = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/fp_add_unit.sv
// fp_add_unit: multi-cycle IEEE-754 adder (FTZ/DAZ, round-to-nearest-even) behind an en/ready handshake
module fp_add_unit
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = FP_EXP_WIDTH,
  parameter int MAN_WIDTH = FP_MAN_WIDTH,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ready
);
  localparam int W = MAN_WIDTH + 4;
  localparam int CW = $clog2(W + 1);
  localparam int XW = EXP_WIDTH + CW + 1;
  localparam int EMAX = (1 << EXP_WIDTH) - 1;

  fp_add_state_t state, next;
  logic aph;
  logic [DATA_WIDTH-1:0] a_r, b_r, spc_v, res;
  logic sgn, zsgn, sub, spc, zero;
  logic [EXP_WIDTH-1:0] dsh;
  logic signed [XW-1:0] exp_r, re;
  logic [W-1:0] man_b, man_s, xa, xb, sh, aligned;
  logic [W:0] sum;
  logic sa, sb, swap, ia, ib, nan, up;
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [MAN_WIDTH-1:0] ma, mb, frac;
  logic [MAN_WIDTH+1:0] rm;
  logic [CW-1:0] lz;

  assign {sa, ea, ma} = a_r;
  assign {sb, eb, mb} = b_r;
  // subnormals are flushed here: a zero exponent yields a zero extended mantissa
  assign xa = (ea == '0) ? '0 : {1'b1, ma, 3'b000};
  assign xb = (eb == '0) ? '0 : {1'b1, mb, 3'b000};
  assign swap = {eb, xb} > {ea, xa};
  assign ia = (&ea) && ma == '0;
  assign ib = (&eb) && mb == '0;
  assign nan = ((&ea) && ma != '0) || ((&eb) && mb != '0) || (ia && ib && (sa ^ sb));

  assign sh = man_s >> dsh;
  assign aligned = (int'(dsh) >= MAN_WIDTH + 3) ? W'(|man_s)
                 : {sh[W-1:1], sh[0] | (|(man_s & ~({W{1'b1}} << dsh)))};

  fp_lzc #(.WIDTH(W)) u_lzc (.value(sum[W-1:0]), .count(lz));

  assign up = man_b[2] & (man_b[1] | man_b[0] | man_b[3]);
  assign rm = {1'b0, man_b[W-1:3]} + (MAN_WIDTH + 2)'(up);
  assign re = exp_r + XW'(rm[MAN_WIDTH+1]);
  assign frac = rm[MAN_WIDTH+1] ? rm[MAN_WIDTH:1] : rm[MAN_WIDTH-1:0];
  assign res = spc ? spc_v
             : zero ? {zsgn, {(DATA_WIDTH-1){1'b0}}}
             : re >= XW'(EMAX) ? DATA_WIDTH'(fp_inf(EXP_WIDTH, MAN_WIDTH, sgn))
             : re < XW'(1) ? {sgn, {(DATA_WIDTH-1){1'b0}}}
             : {sgn, re[EXP_WIDTH-1:0], frac};

  // ALIGN spends two cycles: unpack/swap/specials, then the alignment shift
  assign next = !en ? S_IDLE
              : state == S_DONE ? S_DONE
              : (state == S_ALIGN && !aph) ? S_ALIGN
              : fp_add_state_t'(state + 3'd1);

  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      aph <= 1'b0;
      ready <= 1'b0;
      result <= '0;
    end else begin
      state <= next;
      aph <= state == S_ALIGN && !aph && en;
      ready <= next == S_DONE;
      if (state == S_ROUND && en) result <= res;
    end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && en) begin
      a_r <= a;
      b_r <= b;
    end
    if (state == S_ALIGN && !aph) begin
      sgn <= swap ? sb : sa;
      zsgn <= sa & sb;
      sub <= sa ^ sb;
      spc <= nan | ia | ib;
      spc_v <= nan ? DATA_WIDTH'(fp_qnan(EXP_WIDTH, MAN_WIDTH)) : ia ? a_r : b_r;
      exp_r <= XW'(swap ? eb : ea);
      man_b <= swap ? xb : xa;
      man_s <= swap ? xa : xb;
      dsh <= swap ? eb - ea : ea - eb;
    end
    if (state == S_ALIGN && aph) man_s <= aligned;
    if (state == S_ADD) sum <= sub ? {1'b0, man_b} - {1'b0, man_s} : {1'b0, man_b} + {1'b0, man_s};
    if (state == S_NORM) begin
      zero <= sum == '0;
      exp_r <= sum[W] ? exp_r + XW'(1) : exp_r - XW'(lz);
      man_b <= sum[W] ? {sum[W:2], sum[1] | sum[0]} : sum[W-1:0] << lz;
    end
  end
endmodule

// File: tb/tb_fp_add_unit.sv
// tb_fp_add_unit: scoreboard bench for fp_add_unit against an exact fixed-point binary16 model
module tb_fp_add_unit;
  import fp_pkg::*;

  logic clk = 1'b0, reset = 1'b0, en = 1'b0;
  logic [15:0] a = '0, b = '0, result, last_want = '0;
  logic ready, ready_q = 1'b0;
  logic [15:0] held = '0;
  int checks = 0, errors = 0, cyc = 0, op_id = 0;

  typedef struct {
    logic [15:0] val;
    int due;
    int id;
  } exp_t;
  exp_t sb_q[$];
  exp_t cur;

  fp_add_unit dut (.clk(clk), .reset(reset), .en(en), .a(a), .b(b), .result(result), .ready(ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // value in units of 2^-24; subnormal inputs count as zero
  function automatic longint fx(input logic [15:0] v);
    longint m;
    m = (v[14:10] == 5'd0) ? 64'sd0 : (longint'(1024 + int'(v[9:0])) << (int'(v[14:10]) - 1));
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    bit xn, yn, xi, yi;
    longint s, mag, q, rem, half;
    int p, sh, e;
    xn = (&x[14:10]) && x[9:0] != 0;
    yn = (&y[14:10]) && y[9:0] != 0;
    xi = (&x[14:10]) && x[9:0] == 0;
    yi = (&y[14:10]) && y[9:0] == 0;
    if (xn || yn || (xi && yi && x[15] != y[15])) return 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    s = fx(x) + fx(y);
    if (s == 0) return {x[15] & y[15], 15'd0};
    mag = s < 0 ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p < 10) return {s < 0, 15'd0};
    sh = p - 10;
    q = mag >> sh;
    rem = mag - (q << sh);
    half = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
    if (sh > 0 && (rem > half || (rem == half && q[0]))) q++;
    if (q == 2048) begin
      q = 1024;
      sh++;
    end
    e = sh - 14 + fp_bias(5);
    if (e >= 31) return {s < 0, 5'h1F, 10'd0};
    return {s < 0, e[4:0], q[9:0]};
  endfunction

  always @(negedge clk) begin
    if (ready === 1'b1 && ready_q !== 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready result=%h", result);
      end else begin
        cur = sb_q.pop_front();
        if (result !== cur.val) begin
          errors++;
          $display("FAIL op%0d result got=%h want=%h", cur.id, result, cur.val);
        end
        checks++;
        if (cyc != cur.due) begin
          errors++;
          $display("FAIL op%0d latency ready_at=%0d want=%0d", cur.id, cyc, cur.due);
        end
      end
      held = result;
    end else if (ready === 1'b1) begin
      checks++;
      if (result !== held) begin
        errors++;
        $display("FAIL hold_stable got=%h want=%h", result, held);
      end
    end
    ready_q = ready;
  end

  task automatic push(input logic [15:0] w);
    sb_q.push_back('{w, cyc + 6, op_id});
    op_id++;
    last_want = w;
  endtask

  task automatic finish_op(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    a = 16'($urandom);
    b = 16'($urandom);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout waited=%0d want<=6", n);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    repeat (hold) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_fall got=%b want=0", ready);
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w, input int hold);
    a = x;
    b = y;
    en = 1'b1;
    push(w);
    finish_op(hold);
  endtask

  logic [15:0] dir_a [9] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h3C00, 16'h3C01, 16'h7C00, 16'h7BFF, 16'h0200, 16'h7E01};
  logic [15:0] dir_b [9] = '{16'h4000, 16'hBC00, 16'h8000, 16'h1000, 16'h1000, 16'hFC00, 16'h7BFF, 16'h8000, 16'h3C00};
  logic [15:0] dir_r [9] = '{16'h4200, 16'h0000, 16'h8000, 16'h3C00, 16'h3C02, 16'h7E00, 16'h7C00, 16'h0000, 16'h7E00};

  initial begin
    logic [15:0] x, y;
    repeat (3) @(negedge clk);
    checks += 2;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    if (result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_result got=%h want=0000", result);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i], dir_r[i], i % 3);
    // abort in ADD: result keeps the previous value and ready stays low
    a = 16'h4400;
    b = 16'h4400;
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || result !== last_want) begin
        errors++;
        $display("FAIL abort ready=%b result=%h want ready=0 result=%h", ready, result, last_want);
      end
    end
    issue(16'h3C00, 16'h4000, 16'h4200, 0);
    // reset while in DONE with en still high, then recapture right after release
    a = 16'h4000;
    b = 16'h4000;
    en = 1'b1;
    push(16'h4400);
    @(negedge clk);
    for (int n = 0; n < 20 && ready !== 1'b1; n++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_done_ready got=%b want=0", ready);
    end
    if (result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_done_result got=%h want=0000", result);
    end
    reset = 1'b1;
    a = 16'h3C00;
    b = 16'h3C00;
    push(16'h4000);
    finish_op(1);
    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'($urandom);
        1: y = {~x[15], x[14:0] ^ 15'($urandom_range(0, 7))};
        2: y = {1'($urandom), x[14:10] - 5'($urandom_range(0, 12)), 10'($urandom)};
        default: y = {x[15], 5'($urandom_range(0, 31)), 10'($urandom)};
      endcase
      issue(x, y, ref_add(x, y), $urandom_range(0, 2));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
